// File: rtl/scope_column_scheduler.sv
// Frame-buffer write sequencer for the scope display: clears the buffer, then paints one
// quantized sample per vertical-blanking edge as a full column at a scrolling pointer.
module scope_column_scheduler #(
    parameter logic [11:0] TRACE_COLOR = 12'h0F0,
    parameter logic [11:0] AXIS_COLOR  = 12'hFFF,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblank,
    input  logic [1:0]  mode,
    input  logic        sample_valid,
    input  logic [7:0]  sample_value,
    output logic        sample_ready,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [11:0] fb_wdata,
    output logic [9:0]  col_ptr,
    output logic        init_done,
    output logic        busy
);

    localparam logic [18:0] LastAddr  = 19'(H_RES * V_RES - 1);
    localparam logic [18:0] RowStride = 19'(H_RES);
    localparam logic [8:0]  LastRow   = 9'(V_RES - 1);
    localparam logic [9:0]  LastCol   = 10'(H_RES - 1);

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StWaitVb,
        StDraw,
        StAdvance
    } state_e;

    state_e      state_q;
    logic        vblank_q;
    logic [18:0] addr_q;
    logic [8:0]  row_q;
    logic [4:0]  level_q;

    logic        vb_rise;
    logic [3:0]  volts;
    logic [1:0]  bucket;
    logic [4:0]  level_d;
    logic [8:0]  trace_lo;
    logic [8:0]  trace_hi;
    logic [11:0] pixel;

    assign vb_rise = vblank & ~vblank_q;

    // Sample quantization: 3 levels per volt, voltage saturated at 5.
    always_comb begin
        volts   = (sample_value[7:4] > 4'd5) ? 4'd5 : sample_value[7:4];
        bucket  = 2'd0;
        if (sample_value[3:0] > 4'd6) begin
            bucket = 2'd2;
        end else if (sample_value[3:0] > 4'd3) begin
            bucket = 2'd1;
        end
        level_d = {1'b0, volts} + {volts, 1'b0} + {3'b000, bucket};
    end

    // Trace band is 13 rows tall and moves up 13 rows per level; it never meets the axis.
    always_comb begin
        trace_lo = 9'd221 - (9'(level_q) * 9'd13);
        trace_hi = trace_lo + 9'd12;
        pixel    = 12'h000;
        if (row_q >= trace_lo && row_q <= trace_hi) begin
            pixel = TRACE_COLOR;
        end else if (row_q >= 9'd235 && row_q <= 9'd240) begin
            pixel = AXIS_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StClear;
            vblank_q     <= 1'b0;
            addr_q       <= '0;
            row_q        <= '0;
            level_q      <= '0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_wdata     <= '0;
            sample_ready <= 1'b0;
            col_ptr      <= '0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            vblank_q <= vblank;
            fb_we    <= 1'b0;
            case (state_q)
                StClear: begin
                    fb_we        <= 1'b1;
                    fb_addr      <= addr_q;
                    fb_wdata     <= 12'h000;
                    sample_ready <= 1'b0;
                    busy         <= 1'b1;
                    if (addr_q == LastAddr) begin
                        addr_q    <= '0;
                        init_done <= 1'b1;
                        col_ptr   <= '0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        addr_q <= addr_q + 19'd1;
                    end
                end
                StIdle: begin
                    if (mode == 2'd3) begin
                        addr_q       <= '0;
                        sample_ready <= 1'b0;
                        busy         <= 1'b1;
                        state_q      <= StClear;
                    end else if (sample_valid && sample_ready && !mode[0]) begin
                        level_q      <= level_d;
                        sample_ready <= 1'b0;
                        busy         <= 1'b1;
                        state_q      <= StWaitVb;
                    end else begin
                        // Modes 0 and 2 run, mode 1 holds.
                        sample_ready <= !mode[0];
                    end
                end
                StWaitVb: begin
                    if (vb_rise) begin
                        addr_q  <= {9'b0, col_ptr};
                        row_q   <= '0;
                        state_q <= StDraw;
                    end
                end
                StDraw: begin
                    fb_we    <= 1'b1;
                    fb_addr  <= addr_q;
                    fb_wdata <= pixel;
                    addr_q   <= addr_q + RowStride;
                    row_q    <= row_q + 9'd1;
                    if (row_q == LastRow) begin
                        state_q <= StAdvance;
                    end
                end
                StAdvance: begin
                    col_ptr <= (col_ptr == LastCol) ? 10'd0 : col_ptr + 10'd1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    addr_q  <= '0;
                    busy    <= 1'b1;
                    state_q <= StClear;
                end
            endcase
        end
    end

endmodule
